// File: rtl/draw_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// draw_scheduler_pkg
// Shared definitions for the frame draw scheduler:
//   - default frame-buffer geometry and pass timeout
//   - requester (drawer) indices: BG, FG, OVL
//   - game-state encodings as delivered by the game controller
//   - scheduler FSM state type and a helper mapping a pass state to its drawer
// -----------------------------------------------------------------------------
package draw_scheduler_pkg;

  // 64x32 matrix, RGB upper/lower half pixel word.
  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 6;
  localparam int TIMEOUT_DEF = 4096;

  // Drawer indices into the packed req_* buses.
  localparam int NUM_REQ = 3;
  localparam int REQ_BG  = 0;
  localparam int REQ_FG  = 1;
  localparam int REQ_OVL = 2;

  typedef enum logic [1:0] {
    GS_IDLE        = 2'b00,
    GS_SONG_SELECT = 2'b01,
    GS_START_SCENE = 2'b10,
    GS_GAME_PLAY   = 2'b11
  } game_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_BG,
    S_FG,
    S_OVL,
    S_SWAP
  } sched_state_e;

  // Drawer owning the write port in a given pass state (BG for non-pass states;
  // callers qualify with their own "in pass" term).
  function automatic logic [1:0] pass_idx(input sched_state_e s);
    case (s)
      S_FG:    return 2'(REQ_FG);
      S_OVL:   return 2'(REQ_OVL);
      default: return 2'(REQ_BG);
    endcase
  endfunction

endpackage

// File: rtl/fb_write_mux.sv
// -----------------------------------------------------------------------------
// fb_write_mux
// 3:1 selector from the drawers' write ports onto a single frame-buffer port.
// Purely combinational; when en is low all outputs are 0.
//   en        in   1                 a drawer currently owns the port
//   sel       in   2                 owning drawer index (0=BG,1=FG,2=OVL)
//   req_we    in   NUM_REQ           per-drawer write enables
//   req_addr  in   NUM_REQ*ADDR_W    per-drawer addresses, idx i at [i*ADDR_W +: ADDR_W]
//   req_data  in   NUM_REQ*DATA_W    per-drawer data, same packing
//   we/addr/data out                 selected write port
// -----------------------------------------------------------------------------
module fb_write_mux
  import draw_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                        en,
  input  logic [1:0]                  sel,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        we,
  output logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           data
);

  // NOTE: every signal written here is given a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    we   = 1'b0;
    addr = '0;
    data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && (sel == 2'(i))) begin
        we   = req_we[i];
        addr = req_addr[i*ADDR_W +: ADDR_W];
        data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Sequences one frame of drawing into the back frame buffer on each frame_tick:
// clear every address to 0, run the BG / FG / OVL drawer passes that the
// latched game state calls for, then pulse swap.
//   clk, rst       clock; asynchronous active-low reset
//   frame_tick     pulse: a new frame may be drawn (honoured only when idle)
//   game_state     current game state; latched into frame_state at frame start
//   clr_err        pulse: clears overrun / timeout_err (a same-cycle set wins)
//   req_start      one-cycle start pulse per drawer (0=BG,1=FG,2=OVL)
//   req_done       drawer completion pulses
//   req_we/addr/data  drawer write ports, packed per drawer
//   fb_we/addr/data   frame-buffer write port
//   swap           pulse: back buffer complete
//   busy           high whenever a frame is in progress
//   frame_state    game state latched for the current frame
//   overrun        sticky: frame_tick arrived while busy
//   timeout_err    sticky: a drawer pass was cut off by the timeout
// -----------------------------------------------------------------------------
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic [1:0]                  game_state,
  input  logic                        clr_err,
  output logic [NUM_REQ-1:0]          req_start,
  input  logic [NUM_REQ-1:0]          req_done,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        fb_we,
  output logic [ADDR_W-1:0]           fb_addr,
  output logic [DATA_W-1:0]           fb_data,
  output logic                        swap,
  output logic                        busy,
  output logic [1:0]                  frame_state,
  output logic                        overrun,
  output logic                        timeout_err
);

  // One counter serves both the clear sweep (address) and the pass cycle count,
  // so it is sized for whichever needs more bits.
  localparam int TMO_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_W    = (ADDR_W > TMO_BITS) ? ADDR_W : TMO_BITS;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'((1 << ADDR_W) - 1);
  // Pass cycles are numbered 0..TIMEOUT-1; the last one forces the advance.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       frame_state_q, frame_state_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic             in_pass;
  logic             pass_first;
  logic             done_ok;
  logic             pass_tmo;
  logic             tmo_set;
  logic [1:0]       cur_idx;

  logic              mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_data;

  // Pass qualifiers. A done in the start cycle is ignored: the drawer has not
  // yet seen its start pulse, so it cannot belong to this pass.
  always_comb begin
    in_pass    = (state_q == S_BG) || (state_q == S_FG) || (state_q == S_OVL);
    cur_idx    = pass_idx(state_q);
    pass_first = (cnt_q == '0);
    done_ok    = in_pass && !pass_first && req_done[cur_idx];
    pass_tmo   = in_pass && (cnt_q == TMO_LAST);
  end

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    frame_state_d = frame_state_q;
    tmo_set       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (frame_tick) begin
          frame_state_d = game_state;
          state_d       = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d = '0;
          // A blank (IDLE) frame skips every drawer pass.
          if (frame_state_q == GS_IDLE) state_d = S_SWAP;
          else                          state_d = S_BG;
        end
      end

      S_BG, S_FG, S_OVL: begin
        if (done_ok || pass_tmo) begin
          cnt_d   = '0;
          // Done wins over a coincident timeout.
          tmo_set = !done_ok;
          case (state_q)
            S_BG:    state_d = S_FG;
            S_FG: begin
              // Only game play draws the overlay.
              if (frame_state_q == GS_GAME_PLAY) state_d = S_OVL;
              else                               state_d = S_SWAP;
            end
            default: state_d = S_SWAP;
          endcase
        end
      end

      S_SWAP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Ticks are never queued; a tick outside idle only raises the flag.
    overrun_d     = (overrun_q && !clr_err) || (frame_tick && (state_q != S_IDLE));
    timeout_err_d = (timeout_err_q && !clr_err) || tmo_set;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      frame_state_q <= 2'b00;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_state_q <= frame_state_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  fb_write_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fb_write_mux (
    .en       (in_pass),
    .sel      (cur_idx),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_data (req_data),
    .we       (mux_we),
    .addr     (mux_addr),
    .data     (mux_data)
  );

  // Outputs decode straight from the state flops, so reset clears them at once.
  always_comb begin
    fb_we   = mux_we;
    fb_addr = mux_addr;
    fb_data = mux_data;
    if (state_q == S_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = cnt_q[ADDR_W-1:0];
      fb_data = '0;
    end
    req_start = '0;
    if (in_pass && pass_first) req_start[cur_idx] = 1'b1;
  end

  assign swap        = (state_q == S_SWAP);
  assign busy        = (state_q != S_IDLE);
  assign frame_state = frame_state_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
